regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Arbitrates the single write port of the 32x32 register file between three sources: pipeline writeback (WB), a clear sequencer that zeroes every register on command, and a debug/loader port with a request/acknowledge handshake. Sits between the WB stage and the register file's RegWrite/WriteReg/WriteData inputs. Raises `busy` during a clear sweep so the hazard unit can stall issue.

## Interface
- `NREGS`, 32: number of registers swept (power of two)
- `AW`, 5: register address width, log2(NREGS)
- `DW`, 32: data width
- `clk`  in  1: clock, all logic on rising edge
- `reset`  in  1: asynchronous, active-high
- `wb_we`  in  1: writeback write enable
- `wb_reg`  in  AW: writeback destination
- `wb_data`  in  DW: writeback data
- `clear_req`  in  1: one-cycle pulse, start clear sweep
- `dbg_req`  in  1: debug write request, held until `dbg_ack`
- `dbg_reg`  in  AW: debug destination, stable while `dbg_req`=1
- `dbg_data`  in  DW: debug data, stable while `dbg_req`=1
- `dbg_ack`  out  1: one-cycle pulse, debug write performed
- `busy`  out  1: clear sweep in progress
- `clr_done`  out  1: one-cycle pulse, sweep finished
- `rf_we`  out  1: to register file RegWrite
- `rf_waddr`  out  AW: to register file WriteReg
- `rf_wdata`  out  DW: to register file WriteData

## Operation
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `dbg_ack`=0, `busy`=0, `clr_done`=0; FSM in IDLE; sweep index 0.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when `clear_req`=1; index loaded with 0.
  - SWEEP -> DONE on the cycle the write to index NREGS-1 is granted.
  - DONE -> IDLE unconditionally after one cycle; `clr_done`=1 only in DONE.
  - `clear_req` in SWEEP or DONE is ignored (no restart, no queueing).
- Fixed priority each cycle: WB > SWEEP > DBG.
  - WB granted whenever `wb_we`=1; WB is never stalled or dropped.
  - Sweep write (address = index, data = 0) granted in SWEEP when `wb_we`=0; index increments only on grant. A WB write pauses the sweep by one slot.
  - DBG granted when `dbg_req`=1, `wb_we`=0, state is IDLE or DONE, and `clear_req`=0.
- Address-0 rule: WB and DBG writes to register 0 produce `rf_we`=0. A DBG write to 0 is still acknowledged. Sweep writes to register 0 are issued (value is 0).
- WB write issued during SWEEP to an already-swept register persists. WB write to a not-yet-swept register is overwritten by the sweep.
- `busy`=1 exactly while the FSM is in SWEEP.
- `dbg_req` dropped before `dbg_ack`: request cancelled, no write, no ack.

## Timing
- Inputs sampled at rising edge N. `rf_*` for the granted source are registered and valid in cycle N+1 (latency 1).
- `dbg_ack` is asserted in the same cycle as the corresponding `rf_we`, or as the suppressed write for address 0. The requester may change `dbg_reg`/`dbg_data` or drop `dbg_req` in that cycle. The arbiter does not re-grant the same request: `dbg_req` seen in the `dbg_ack` cycle is a new request.
- `clear_req` at edge N: `busy`=1 from N+1.
  - Uncontended sweep: writes registers 0..NREGS-1 on cycles N+1..N+NREGS (registered view).
  - `busy` falls and `clr_done` pulses at N+NREGS+1.
  - Each interleaved WB write adds one cycle.
- With no grant, `rf_we`=0. `rf_waddr`/`rf_wdata` hold their last values.
- Reset asserted mid-sweep: all outputs go to reset values immediately and asynchronously. The sweep is abandoned and not resumed after release. Any pending DBG request restarts arbitration from IDLE.

## Test plan
- Reset, then WB write reg 8 = 0x0000000A -> next cycle `rf_we`=1, `rf_waddr`=8, `rf_wdata`=0xA. WB write reg 0 = 5 -> `rf_we`=0.
- DBG write reg 17 = 0x1234 with idle WB -> `rf_we`=1, addr 17, data 0x1234, `dbg_ack` pulse 1 cycle. With `wb_we`=1 for 3 cycles, ack is delayed exactly 3 cycles and WB writes appear first.
- `clear_req` pulse, no other traffic -> 32 consecutive writes of 0 to addresses 0..31. `busy` high 32 cycles. `clr_done` 1 cycle after the last write.
- Clear with WB writes to reg 9 at sweep index 4 and reg 2 at sweep index 20 -> sweep lasts 34 cycles. Reg 9 ends 0 (swept later), reg 2 keeps the WB value. No address is skipped or repeated.
- `dbg_req` held during a sweep -> no ack until the DONE cycle, acked then. A second `clear_req` mid-sweep changes nothing.
- Assert `reset` at sweep index 10 -> `busy`, `rf_we`, `clr_done` go to 0 immediately. After release, no further sweep writes occur.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the register file between three sources,
// in fixed priority order:
//   1. pipeline writeback (WB)   - never stalled or dropped
//   2. clear sweep               - zeroes registers 0..NREGS-1, one per free slot
//   3. debug/loader port (DBG)   - request/acknowledge handshake
//
// Ports:
//   clk, reset                   clock (rising edge), async active-high reset
//   wb_we, wb_reg, wb_data       writeback request
//   clear_req                    one-cycle pulse that starts a clear sweep
//   dbg_req, dbg_reg, dbg_data   debug write request, held until dbg_ack
//   dbg_ack                      one-cycle pulse, debug write performed
//   busy                         clear sweep in progress (registered)
//   clr_done                     one-cycle pulse, sweep finished (registered)
//   rf_we, rf_waddr, rf_wdata    registered write port to the register file
//
// Every output is registered, so it reflects the grant (or FSM state) of the
// previous rising edge. Register 0 is hard-wired to zero: WB and DBG writes to
// it are granted but issued with rf_we=0; sweep writes to it are issued.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    input  logic          clear_req,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_reg,
    input  logic [DW-1:0] dbg_data,
    output logic          dbg_ack,
    output logic          busy,
    output logic          clr_done,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic          busy_r;
    logic          clr_done_r;
    logic          dbg_ack_r;
    logic          rf_we_r;
    logic [AW-1:0] rf_waddr_r;
    logic [DW-1:0] rf_wdata_r;

    logic          wb_grant_s;
    logic          sweep_grant_s;
    logic          dbg_grant_s;
    logic          last_idx_s;

    // Register 0 is constant zero, so a write to it must not raise rf_we.
    function automatic logic is_writable(input logic [AW-1:0] addr);
        return (addr != {AW{1'b0}});
    endfunction

    // Fixed-priority grant decode: WB > SWEEP > DBG.
    always_comb begin
        wb_grant_s    = 1'b0;
        sweep_grant_s = 1'b0;
        dbg_grant_s   = 1'b0;
        last_idx_s    = 1'b0;
        if (wb_we) begin
            wb_grant_s = 1'b1;
        end else if (state_r == SWEEP) begin
            sweep_grant_s = 1'b1;
        end else if (dbg_req && !clear_req &&
                     ((state_r == IDLE) || (state_r == DONE))) begin
            // A clear request in the same cycle keeps the slot free for the
            // sweep that is about to start.
            dbg_grant_s = 1'b1;
        end else begin
            wb_grant_s = 1'b0;
        end
        last_idx_s = (idx_r == AW'(NREGS - 1));
    end

    // Clear-sweep FSM with its registered busy/clr_done status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            idx_r      <= {AW{1'b0}};
            busy_r     <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            // Status outputs trail the state by one cycle, lining busy up
            // with the registered sweep writes on rf_*.
            busy_r     <= (state_r == SWEEP);
            clr_done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (clear_req) begin
                        state_r <= SWEEP;
                        idx_r   <= {AW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SWEEP: begin
                    // clear_req is ignored here: no restart, no queueing.
                    if (sweep_grant_s) begin
                        idx_r <= idx_r + AW'(1);
                        if (last_idx_s) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= SWEEP;
                        end
                    end else begin
                        state_r <= SWEEP;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered write port and debug acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
            dbg_ack_r  <= 1'b0;
        end else begin
            // The ack follows the grant even when the write itself is
            // suppressed for register 0.
            dbg_ack_r <= dbg_grant_s;
            if (wb_grant_s) begin
                rf_we_r    <= is_writable(wb_reg);
                rf_waddr_r <= wb_reg;
                rf_wdata_r <= wb_data;
            end else if (sweep_grant_s) begin
                rf_we_r    <= 1'b1;
                rf_waddr_r <= idx_r;
                rf_wdata_r <= {DW{1'b0}};
            end else if (dbg_grant_s) begin
                rf_we_r    <= is_writable(dbg_reg);
                rf_waddr_r <= dbg_reg;
                rf_wdata_r <= dbg_data;
            end else begin
                // No grant: address and data hold their last values.
                rf_we_r <= 1'b0;
            end
        end
    end

    assign dbg_ack  = dbg_ack_r;
    assign busy     = busy_r;
    assign clr_done = clr_done_r;
    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

endmodule
